// File: rtl/io_pkg.sv
// Shared constants for the I/O port bridge at the core's memory-mapped I/O address.
package io_pkg;
    localparam int          DATA_W_DEF    = 16;
    localparam logic [15:0] IO_ADDR       = 16'd255;
    localparam logic [15:0] EMPTY_VAL_DEF = 16'h0000;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; dout is a combinational read of the head entry.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB distinguishes a full FIFO from an empty one when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the array is reset so the head reads as zero after reset instead of stale data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/io_port_bridge.sv
// Memory-mapped I/O endpoint: TX/RX FIFOs between the core and an external valid/ready device.
module io_port_bridge
    import io_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                TX_DEPTH  = 4,
    parameter int                RX_DEPTH  = 4,
    parameter logic [DATA_W-1:0] EMPTY_VAL = EMPTY_VAL_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wr_en,
    input  logic              io_rd_en,
    input  logic [DATA_W-1:0] io_out,
    output logic [DATA_W-1:0] io_in,
    output logic              io_stall,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rx_avail,
    output logic              underflow,
    input  logic              clear_flags
);
    logic              tx_full;
    logic              tx_empty;
    logic              rx_full;
    logic              rx_empty;
    logic [DATA_W-1:0] rx_head;

    // Pushes and pops are gated by full/empty inside the FIFO, using pre-edge flags.
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (io_wr_en),
        .pop   (tx_ready),
        .din   (io_out),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_valid),
        .pop   (io_rd_en),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // A full TX stalls even if the device drains a word this cycle.
    assign io_stall = io_wr_en && tx_full;
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign rx_avail = !rx_empty;
    assign io_in    = rx_empty ? EMPTY_VAL : rx_head;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            underflow <= 1'b0;
        end else if (clear_flags) begin
            underflow <= 1'b0;
        end else if (io_rd_en && rx_empty) begin
            underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_io_port_bridge.sv
// Scoreboard bench for io_port_bridge: expected words queued at stimulus, compared on output.
module tb_io_port_bridge;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_wr_en;
    logic        io_rd_en;
    logic [15:0] io_out;
    logic [15:0] io_in;
    logic        io_stall;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_avail;
    logic        underflow;
    logic        clear_flags;

    int checks = 0;
    int errors = 0;
    logic [15:0] tx_q[$];
    logic [15:0] rx_q[$];

    io_port_bridge dut (
        .clock       (clock),
        .reset       (reset),
        .io_wr_en    (io_wr_en),
        .io_rd_en    (io_rd_en),
        .io_out      (io_out),
        .io_in       (io_in),
        .io_stall    (io_stall),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_avail    (rx_avail),
        .underflow   (underflow),
        .clear_flags (clear_flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic store(input logic [15:0] v);
        io_wr_en = 1'b1;
        io_out   = v;
        settle();
        check("store_no_stall", io_stall, 1'b0);
        tx_q.push_back(v);
        step();
        io_wr_en = 1'b0;
    endtask

    task automatic dev_send(input logic [15:0] v);
        rx_valid = 1'b1;
        rx_data  = v;
        settle();
        check("rx_ready_send", rx_ready, 1'b1);
        rx_q.push_back(v);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic core_read();
        logic [15:0] exp;
        io_rd_en = 1'b1;
        settle();
        if (rx_q.size() == 0) exp = 16'h0000;
        else exp = rx_q.pop_front();
        check("io_in_read", io_in, exp);
        step();
        io_rd_en = 1'b0;
    endtask

    task automatic tx_drain(input int max_cycles);
        int n = 0;
        tx_ready = 1'b1;
        settle();
        while (tx_valid && n < max_cycles) begin
            if (tx_q.size() == 0) check("tx_extra_word", tx_data, 16'hxxxx);
            else check("tx_data_order", tx_data, tx_q.pop_front());
            step();
            n++;
        end
        check("tx_drain_done", tx_valid, 1'b0);
        check("tx_queue_empty", tx_q.size(), 0);
        tx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; io_wr_en = 1'b0; io_rd_en = 1'b0; io_out = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; clear_flags = 1'b0;
        step(); step();
        reset = 1'b1;
        step();

        check("rst_io_in", io_in, 16'h0000);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 16'h0000);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_rx_avail", rx_avail, 1'b0);
        check("rst_io_stall", io_stall, 1'b0);
        check("rst_underflow", underflow, 1'b0);

        // TX fill, stall while full, then pop frees a slot for the held store
        store(16'h1111);
        check("tx_latency", tx_valid, 1'b1);
        store(16'h2222);
        store(16'h3333);
        store(16'h4444);
        check("tx_head", tx_data, tx_q[0]);
        io_wr_en = 1'b1;
        io_out   = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("tx_stall_held", io_stall, 1'b1);
            step();
        end
        tx_ready = 1'b1;
        settle();
        check("tx_stall_on_pop", io_stall, 1'b1);
        check("tx_pop_word", tx_data, tx_q.pop_front());
        step();
        tx_ready = 1'b0;
        settle();
        check("tx_stall_released", io_stall, 1'b0);
        tx_q.push_back(16'h5555);
        step();
        io_wr_en = 1'b0;
        tx_drain(20);

        // RX path: device words appear on io_in in order
        dev_send(16'hABCD);
        check("rx_latency", io_in, 16'hABCD);
        check("rx_avail_set", rx_avail, 1'b1);
        dev_send(16'h1234);
        core_read();
        check("rx_next_head", io_in, 16'h1234);
        core_read();
        check("rx_empty_val", io_in, 16'h0000);
        check("rx_avail_clr", rx_avail, 1'b0);
        check("no_underflow_yet", underflow, 1'b0);

        // Underflow sticky, then clear wins over a simultaneous set
        core_read();
        check("underflow_set", underflow, 1'b1);
        step();
        check("underflow_sticky", underflow, 1'b1);
        clear_flags = 1'b1;
        io_rd_en    = 1'b1;
        step();
        clear_flags = 1'b0;
        io_rd_en    = 1'b0;
        check("underflow_cleared", underflow, 1'b0);

        // RX full: held device word lands after the pop frees a slot
        for (int i = 1; i <= 4; i++) dev_send(16'hA000 + 16'(i));
        check("rx_full_ready", rx_ready, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 16'hA005;
        io_rd_en = 1'b1;
        settle();
        check("rx_full_no_push", rx_ready, 1'b0);
        check("rx_full_pop", io_in, rx_q.pop_front());
        step();
        io_rd_en = 1'b0;
        check("rx_ready_again", rx_ready, 1'b1);
        rx_q.push_back(16'hA005);
        step();
        rx_valid = 1'b0;
        check("rx_full_again", rx_ready, 1'b0);
        for (int i = 0; i < 4; i++) core_read();
        check("rx_drained", rx_avail, 1'b0);

        // Asynchronous reset discards buffered words in both directions
        for (int i = 1; i <= 3; i++) store(16'h0101 * 16'(i));
        dev_send(16'hB001);
        dev_send(16'hB002);
        check("pre_rst_tx_valid", tx_valid, 1'b1);
        check("pre_rst_io_in", io_in, 16'hB001);
        #2;
        reset = 1'b0;
        #1;
        check("async_tx_valid", tx_valid, 1'b0);
        check("async_tx_data", tx_data, 16'h0000);
        check("async_io_in", io_in, 16'h0000);
        check("async_rx_avail", rx_avail, 1'b0);
        tx_q.delete();
        rx_q.delete();
        step();
        reset = 1'b1;
        step();
        store(16'h7777);
        check("post_rst_tx", tx_data, 16'h7777);
        tx_drain(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, reached %0t", $time);
        $fatal(1);
    end
endmodule
